// File: rtl/fir_cmac_engine.sv
// Time-multiplexed complex FIR engine: one complex multiply-accumulate per cycle over all
// taps, then a rounded and saturated complex output held on a push/stop handshake.
module fir_cmac_engine #(
    parameter int NTAPS = 15,
    parameter int W     = 27,
    parameter int FRAC  = 24,
    parameter int ACCW  = 60
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic signed [W-1:0] Coef_Re  [NTAPS],
    input  logic signed [W-1:0] Coef_Img [NTAPS],
    input  logic                PushIn,
    input  logic signed [W-1:0] DataI,
    input  logic signed [W-1:0] DataQ,
    output logic                StopIn,
    output logic                PushOut,
    output logic signed [W-1:0] OutI,
    output logic signed [W-1:0] OutQ,
    input  logic                StopOut
);

    localparam int KW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int PW = 2 * W;

    localparam logic signed [ACCW-1:0] ONE_C   = ACCW'(1'b1);
    localparam logic signed [ACCW-1:0] RND_C   = ONE_C <<< (FRAC - 1);
    localparam logic signed [ACCW-1:0] SAT_MAX = (ONE_C <<< (W - 1)) - ONE_C;
    localparam logic signed [ACCW-1:0] SAT_MIN = -(ONE_C <<< (W - 1));

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [KW-1:0]          r_k;
    logic signed [ACCW-1:0] r_acc_re;
    logic signed [ACCW-1:0] r_acc_im;
    logic signed [W-1:0]    r_xi [NTAPS];
    logic signed [W-1:0]    r_xq [NTAPS];

    logic signed [W-1:0]    w_c_re;
    logic signed [W-1:0]    w_c_im;
    logic signed [W-1:0]    w_x_i;
    logic signed [W-1:0]    w_x_q;
    logic signed [PW-1:0]   w_p_rr;
    logic signed [PW-1:0]   w_p_ii;
    logic signed [PW-1:0]   w_p_rq;
    logic signed [PW-1:0]   w_p_ir;
    logic signed [ACCW-1:0] w_sum_re;
    logic signed [ACCW-1:0] w_sum_im;

    // Round half up at the binary point, then clamp to the output range.
    function automatic logic signed [W-1:0] round_sat(input logic signed [ACCW-1:0] v);
        logic signed [ACCW-1:0] t;
        t = (v + RND_C) >>> FRAC;
        if (t > SAT_MAX) begin
            round_sat = SAT_MAX[W-1:0];
        end else if (t < SAT_MIN) begin
            round_sat = SAT_MIN[W-1:0];
        end else begin
            round_sat = t[W-1:0];
        end
    endfunction

    function automatic logic signed [ACCW-1:0] sext_prod(input logic signed [PW-1:0] p);
        sext_prod = {{(ACCW-PW){p[PW-1]}}, p};
    endfunction

    assign StopIn = (r_state != ST_IDLE);

    assign w_c_re = Coef_Re[r_k];
    assign w_c_im = Coef_Img[r_k];
    assign w_x_i  = r_xi[r_k];
    assign w_x_q  = r_xq[r_k];

    assign w_p_rr = w_c_re * w_x_i;
    assign w_p_ii = w_c_im * w_x_q;
    assign w_p_rq = w_c_re * w_x_q;
    assign w_p_ir = w_c_im * w_x_i;

    assign w_sum_re = r_acc_re + sext_prod(w_p_rr) - sext_prod(w_p_ii);
    assign w_sum_im = r_acc_im + sext_prod(w_p_rq) + sext_prod(w_p_ir);

    // Sample acceptance, tap iteration and output handshake.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= ST_IDLE;
            r_k      <= '0;
            r_acc_re <= '0;
            r_acc_im <= '0;
            PushOut  <= 1'b0;
            OutI     <= '0;
            OutQ     <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                r_xi[i] <= '0;
                r_xq[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (PushIn) begin
                        r_xi[0] <= DataI;
                        r_xq[0] <= DataQ;
                        for (int i = 1; i < NTAPS; i++) begin
                            r_xi[i] <= r_xi[i-1];
                            r_xq[i] <= r_xq[i-1];
                        end
                        r_acc_re <= '0;
                        r_acc_im <= '0;
                        r_k      <= '0;
                        r_state  <= ST_MAC;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_MAC: begin
                    r_acc_re <= w_sum_re;
                    r_acc_im <= w_sum_im;
                    if (r_k == KW'(NTAPS - 1)) begin
                        OutI    <= round_sat(w_sum_re);
                        OutQ    <= round_sat(w_sum_im);
                        PushOut <= 1'b1;
                        r_k     <= '0;
                        r_state <= ST_OUT;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                ST_OUT: begin
                    if (!StopOut) begin
                        PushOut <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_OUT;
                    end
                end
                default: begin
                    PushOut <= 1'b0;
                    r_k     <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
